uart_baud_gen: RTL and testbench

- Programmable baud-rate generator for the UART transmitter (Tx) path.
- Divides the system clock `clk` by an integer divisor chosen by the 2-bit `baud_rate` select.
- Produces `baud_clk`, a near-50%-duty square wave at the bit rate, and `baud_tick`, a one-cycle strobe per bit period.
- The Tx shifter advances its state on these outputs.

---
 rtl/uart_baud_gen.sv | 137 +++++++++++++
 tb/tb_uart_baud_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable UART bit-rate generator (square wave + tick).
// Define UART_BAUD_OVERSAMPLE_EN to add the 16x Rx oversample tick os_tick.
module uart_baud_gen #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD0       = 9600,
   parameter int BAUD1       = 19200,
   parameter int BAUD2       = 57600,
   parameter int BAUD3       = 115200,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] baud_rate,
   output logic       baud_clk,
   output logic       baud_tick
`ifdef UART_BAUD_OVERSAMPLE_EN
   ,
   output logic       os_tick
`endif
);

   localparam int DIV0 = (CLK_FREQ_HZ + BAUD0 / 2) / BAUD0;
   localparam int DIV1 = (CLK_FREQ_HZ + BAUD1 / 2) / BAUD1;
   localparam int DIV2 = (CLK_FREQ_HZ + BAUD2 / 2) / BAUD2;
   localparam int DIV3 = (CLK_FREQ_HZ + BAUD3 / 2) / BAUD3;

   function automatic bit div_ok(input int d);
      return (d >= 2) && ((d >> CNT_W) == 0);
   endfunction

   generate
      if (!(div_ok(DIV0) && div_ok(DIV1) &&
            div_ok(DIV2) && div_ok(DIV3))) begin : g_bad_div
         $error("uart_baud_gen: divisor < 2 or wider than CNT_W");
      end
   endgenerate

   logic [1:0]       sel_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] div_m1;
   logic [CNT_W-1:0] half;
   logic             rate_chg;

   assign rate_chg = (baud_rate != sel_q);
   assign cnt_inc  = cnt + CNT_W'(1);

   always_comb begin
      div_m1 = CNT_W'(DIV3 - 1);
      half   = CNT_W'(DIV3 / 2);
      case (sel_q)
         2'd0: begin
            div_m1 = CNT_W'(DIV0 - 1);
            half   = CNT_W'(DIV0 / 2);
         end
         2'd1: begin
            div_m1 = CNT_W'(DIV1 - 1);
            half   = CNT_W'(DIV1 / 2);
         end
         2'd2: begin
            div_m1 = CNT_W'(DIV2 - 1);
            half   = CNT_W'(DIV2 / 2);
         end
         default: begin
            div_m1 = CNT_W'(DIV3 - 1);
            half   = CNT_W'(DIV3 / 2);
         end
      endcase
   end

   // sel_q tracks the select during reset so release never looks like a rate change
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_q     <= baud_rate;
         cnt       <= '0;
         baud_clk  <= 1'b0;
         baud_tick <= 1'b0;
      end else if (rate_chg) begin
         sel_q     <= baud_rate;
         cnt       <= '0;
         baud_clk  <= 1'b0;
         baud_tick <= 1'b0;
      end else if (cnt == div_m1) begin
         cnt       <= '0;
         baud_clk  <= 1'b0;
         baud_tick <= 1'b1;
      end else begin
         cnt       <= cnt_inc;
         baud_clk  <= (cnt_inc >= half);
         baud_tick <= 1'b0;
      end
   end

`ifdef UART_BAUD_OVERSAMPLE_EN
   localparam int OS_DIV0 = (CLK_FREQ_HZ + 8 * BAUD0) / (16 * BAUD0);
   localparam int OS_DIV1 = (CLK_FREQ_HZ + 8 * BAUD1) / (16 * BAUD1);
   localparam int OS_DIV2 = (CLK_FREQ_HZ + 8 * BAUD2) / (16 * BAUD2);
   localparam int OS_DIV3 = (CLK_FREQ_HZ + 8 * BAUD3) / (16 * BAUD3);

   generate
      if (!(div_ok(OS_DIV0) && div_ok(OS_DIV1) &&
            div_ok(OS_DIV2) && div_ok(OS_DIV3))) begin : g_bad_os_div
         $error("uart_baud_gen: oversample divisor < 2 or too wide");
      end
   endgenerate

   logic [CNT_W-1:0] os_cnt;
   logic [CNT_W-1:0] os_m1;

   always_comb begin
      os_m1 = CNT_W'(OS_DIV3 - 1);
      case (sel_q)
         2'd0:    os_m1 = CNT_W'(OS_DIV0 - 1);
         2'd1:    os_m1 = CNT_W'(OS_DIV1 - 1);
         2'd2:    os_m1 = CNT_W'(OS_DIV2 - 1);
         default: os_m1 = CNT_W'(OS_DIV3 - 1);
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         os_cnt  <= '0;
         os_tick <= 1'b0;
      end else if (rate_chg) begin
         os_cnt  <= '0;
         os_tick <= 1'b0;
      end else if (os_cnt == os_m1) begin
         os_cnt  <= '0;
         os_tick <= 1'b1;
      end else begin
         os_cnt  <= os_cnt + CNT_W'(1);
         os_tick <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed + random checks of uart_baud_gen
// against an elapsed-cycle arithmetic model.
module tb_uart_baud_gen;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic [1:0] baud_rate = 2'd3;
   logic       baud_clk;
   logic       baud_tick;
`ifdef UART_BAUD_OVERSAMPLE_EN
   logic       os_tick;
`endif

   uart_baud_gen dut (
      .clk       (clk),
      .resetn    (resetn),
      .baud_rate (baud_rate),
      .baud_clk  (baud_clk),
      .baud_tick (baud_tick)
`ifdef UART_BAUD_OVERSAMPLE_EN
      ,
      .os_tick   (os_tick)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int         k;
   logic [1:0] msel;
   int         cyc;
   int         first_rise;
   int         rise_cyc;
   int         prev_rise;
   int         fall_cyc;
   int         prev_fall;
   int         nrises;
   int         ticks;
   int         os_ticks;
   logic       prev_clk = 1'b0;

   function automatic int div_of(input logic [1:0] r);
      case (r)
         2'd0:    return 5208;
         2'd1:    return 2604;
         2'd2:    return 868;
         default: return 434;
      endcase
   endfunction

   function automatic int os_div_of(input logic [1:0] r);
      case (r)
         2'd0:    return 326;
         2'd1:    return 163;
         2'd2:    return 54;
         default: return 27;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr(input int start);
      cyc        = start;
      first_rise = -1;
      rise_cyc   = -1;
      prev_rise  = -1;
      fall_cyc   = -1;
      prev_fall  = -1;
      nrises     = 0;
      ticks      = 0;
      os_ticks   = 0;
   endtask

   task automatic step();
      int d;
      logic ec;
      logic et;
      @(posedge clk);
      cyc++;
      if (!resetn) begin
         k = 0;
         msel = baud_rate;
      end else if (baud_rate != msel) begin
         k = 0;
         msel = baud_rate;
      end else begin
         k++;
      end
      d  = div_of(msel);
      ec = ((k % d) >= (d / 2));
      et = (k > 0) && ((k % d) == 0);
      #1;
      chk("clk_model", {31'd0, baud_clk}, {31'd0, ec});
      chk("tick_model", {31'd0, baud_tick}, {31'd0, et});
`ifdef UART_BAUD_OVERSAMPLE_EN
      chk("os_model", {31'd0, os_tick},
          {31'd0, (k > 0) && ((k % os_div_of(msel)) == 0)});
      if (os_tick && cyc <= 432) os_ticks++;
`endif
      if (baud_clk && !prev_clk) begin
         if (first_rise < 0) first_rise = cyc;
         prev_rise = rise_cyc;
         rise_cyc  = cyc;
         nrises++;
      end
      if (!baud_clk && prev_clk) begin
         prev_fall = fall_cyc;
         fall_cyc  = cyc;
      end
      if (baud_tick) ticks++;
      prev_clk = baud_clk;
   endtask

   task automatic reset_mid(input int n);
      #2;
      resetn = 1'b0;
      k = 0;
      msel = baud_rate;
      #1;
      chk("async_clk", {31'd0, baud_clk}, 32'd0);
      chk("async_tick", {31'd0, baud_tick}, 32'd0);
      repeat (n) step();
      resetn = 1'b1;
      clr(0);
   endtask

   task automatic wait_clk_high(input string tag);
      int b;
      b = 0;
      while (!baud_clk && b < 6000) begin
         step();
         b++;
      end
      chk(tag, {31'd0, baud_clk}, 32'd1);
   endtask

   initial begin
      int d;
      int b;
      logic [1:0] r;
      #2;
      resetn = 1'b0;
      k = 0;
      msel = baud_rate;
      #1;
      chk("rst_clk", {31'd0, baud_clk}, 32'd0);
      chk("rst_tick", {31'd0, baud_tick}, 32'd0);
      repeat (3) step();
      resetn = 1'b1;
      clr(0);

      repeat (4340) step();
      chk("r3_first_rise", first_rise, 217);
      chk("r3_ticks_4340", ticks, 10);
      chk("r3_period", rise_cyc - prev_rise, 434);
      chk("r3_high", fall_cyc - rise_cyc, 217);
      chk("r3_low", rise_cyc - prev_fall, 217);
`ifdef UART_BAUD_OVERSAMPLE_EN
      chk("os_16_in_432", os_ticks, 16);
`endif

      wait_clk_high("wait_high_rst");
      reset_mid(5);
      b = 0;
      while (first_rise < 0 && b < 1000) begin
         step();
         b++;
      end
      chk("rst_rerise", first_rise, 217);

      b = 0;
      while (!baud_tick && b < 1000) begin
         step();
         b++;
      end
      chk("wait_tick", {31'd0, baud_tick}, 32'd1);
      reset_mid(2);

      wait_clk_high("wait_high_rc");
      baud_rate = 2'd2;
      clr(-1);
      step();
      chk("rc_clk0", {31'd0, baud_clk}, 32'd0);
      repeat (2000) step();
      chk("rc_first_rise", first_rise, 434);
      chk("rc_period", rise_cyc - prev_rise, 868);

      for (int i = 0; i < 3; i++) begin
         r = 2'(i);
         d = div_of(r);
         baud_rate = r;
         clr(-1);
         step();
         b = 0;
         while (nrises < 2 && b < 3 * d) begin
            step();
            b++;
         end
         chk($sformatf("sweep%0d_first", i), first_rise, d / 2);
         chk($sformatf("sweep%0d_period", i), rise_cyc - prev_rise, d);
      end

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            reset_mid($urandom_range(1, 4));
         end else begin
            baud_rate = 2'($urandom_range(0, 3));
         end
         repeat ($urandom_range(50, 2500)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
